// File: rtl/l2_split_pkg.sv
// Shared types for the 64-to-32 bit L2 TCDM splitter: FSM states, half indices and the
// per-half request record.
package l2_split_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2,
        StResp  = 2'd3
    } state_e;

    localparam int unsigned LO = 0;
    localparam int unsigned HI = 1;

    // Widest address the half record can carry; the top slices it down to ADDR_WIDTH.
    localparam int unsigned MaxAddrWidth = 64;

    typedef struct packed {
        logic [MaxAddrWidth-1:0] addr;
        logic                    wen;
        logic [31:0]             wdata;
        logic [3:0]              be;
    } half_req_t;

endpackage

// File: rtl/l2_tcdm_64to32_split_if.sv
// Bus bundle for the splitter: 64-bit upstream port plus the two 32-bit TCDM ports.
// The slave modport is the splitter itself; master is the surrounding environment.
interface l2_tcdm_64to32_split_if #(
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                       req_i;
    logic [ADDR_WIDTH-1:0]      add_i;
    logic                       wen_i;
    logic [63:0]                wdata_i;
    logic [7:0]                 be_i;
    logic                       gnt_o;
    logic                       r_valid_o;
    logic [63:0]                r_rdata_o;

    logic [1:0]                 tcdm_req_o;
    logic [1:0][ADDR_WIDTH-1:0] tcdm_add_o;
    logic [1:0]                 tcdm_wen_o;
    logic [1:0][31:0]           tcdm_wdata_o;
    logic [1:0][3:0]            tcdm_be_o;
    logic [1:0]                 tcdm_gnt_i;
    logic [1:0]                 tcdm_r_valid_i;
    logic [1:0][31:0]           tcdm_r_rdata_i;

    modport slave (
        input  req_i, add_i, wen_i, wdata_i, be_i,
        output gnt_o, r_valid_o, r_rdata_o,
        output tcdm_req_o, tcdm_add_o, tcdm_wen_o, tcdm_wdata_o, tcdm_be_o,
        input  tcdm_gnt_i, tcdm_r_valid_i, tcdm_r_rdata_i
    );

    modport master (
        output req_i, add_i, wen_i, wdata_i, be_i,
        input  gnt_o, r_valid_o, r_rdata_o,
        input  tcdm_req_o, tcdm_add_o, tcdm_wen_o, tcdm_wdata_o, tcdm_be_o,
        output tcdm_gnt_i, tcdm_r_valid_i, tcdm_r_rdata_i
    );

endinterface

// File: rtl/l2_split_half.sv
// One 32-bit half of a split transaction: holds the latched request, tracks grant and
// response completion, and captures the returned word.
module l2_split_half
    import l2_split_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        accept_i,
    input  logic        skip_i,
    input  logic        issue_en_i,
    input  logic        capture_en_i,
    input  half_req_t   half_i,
    input  logic        gnt_i,
    input  logic        r_valid_i,
    input  logic [31:0] r_rdata_i,
    output logic        req_o,
    output half_req_t   half_o,
    output logic        granted_o,
    output logic        done_o,
    output logic [31:0] rdata_o
);

    logic        granted_q;
    logic        done_q;
    logic [31:0] rdata_q;
    half_req_t   half_q;

    assign req_o     = issue_en_i & ~granted_q;
    // Look-ahead flags so the FSM can advance in the same cycle as the last grant/response.
    assign granted_o = granted_q | (req_o & gnt_i);
    assign done_o    = done_q | (capture_en_i & r_valid_i);
    assign half_o    = half_q;
    assign rdata_o   = rdata_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            granted_q <= 1'b0;
            done_q    <= 1'b0;
            rdata_q   <= '0;
            half_q    <= '0;
        end else if (accept_i) begin
            // A skipped half is complete before it starts and returns zero data.
            granted_q <= skip_i;
            done_q    <= skip_i;
            rdata_q   <= '0;
            half_q    <= half_i;
        end else begin
            granted_q <= granted_o;
            if (capture_en_i && r_valid_i) begin
                done_q  <= 1'b1;
                rdata_q <= r_rdata_i;
            end
        end
    end

endmodule

// File: rtl/l2_tcdm_64to32_split.sv
// Splits one 64-bit TCDM transaction into lo/hi 32-bit halves and merges the responses.
// Optional L2_SPLIT_BE_SKIP_EN: writes with an all-zero half byte-enable skip that half.
module l2_tcdm_64to32_split
    import l2_split_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input logic                    clk_i,
    input logic                    rst_ni,
    l2_tcdm_64to32_split_if.slave  bus
);

    state_e                state_q, state_d;
    logic                  accept;
    logic                  issue_en;
    logic                  capture_en;
    logic [1:0]            skip;
    logic [1:0]            granted;
    logic [1:0]            done;
    logic [1:0][31:0]      rdata;
    half_req_t [1:0]       half_in;
    half_req_t [1:0]       half_q;
    logic [ADDR_WIDTH-1:0] base_addr;

    assign accept     = bus.req_i & (state_q == StIdle || state_q == StResp);
    assign issue_en   = (state_q == StIssue);
    assign capture_en = issue_en | (state_q == StWait);

    assign bus.gnt_o     = accept;
    assign bus.r_valid_o = (state_q == StResp);
    assign bus.r_rdata_o = (state_q == StResp) ? {rdata[HI], rdata[LO]} : 64'h0;

`ifdef L2_SPLIT_BE_SKIP_EN
    assign skip[LO] = ~bus.wen_i & (bus.be_i[3:0] == 4'b0000);
    assign skip[HI] = ~bus.wen_i & (bus.be_i[7:4] == 4'b0000);
`else
    assign skip = 2'b00;
`endif

    assign base_addr = {bus.add_i[ADDR_WIDTH-1:3], 3'b000};

    always_comb begin
        half_in[LO].addr  = MaxAddrWidth'(base_addr);
        half_in[LO].wen   = bus.wen_i;
        half_in[LO].wdata = bus.wdata_i[31:0];
        half_in[LO].be    = bus.be_i[3:0];
        half_in[HI].addr  = MaxAddrWidth'(base_addr + ADDR_WIDTH'(4));
        half_in[HI].wen   = bus.wen_i;
        half_in[HI].wdata = bus.wdata_i[63:32];
        half_in[HI].be    = bus.be_i[7:4];
    end

    for (genvar h = 0; h < 2; h++) begin : g_half
        l2_split_half u_half (
            .clk_i        (clk_i),
            .rst_ni       (rst_ni),
            .accept_i     (accept),
            .skip_i       (skip[h]),
            .issue_en_i   (issue_en),
            .capture_en_i (capture_en),
            .half_i       (half_in[h]),
            .gnt_i        (bus.tcdm_gnt_i[h]),
            .r_valid_i    (bus.tcdm_r_valid_i[h]),
            .r_rdata_i    (bus.tcdm_r_rdata_i[h]),
            .req_o        (bus.tcdm_req_o[h]),
            .half_o       (half_q[h]),
            .granted_o    (granted[h]),
            .done_o       (done[h]),
            .rdata_o      (rdata[h])
        );

        assign bus.tcdm_add_o[h]   = half_q[h].addr[ADDR_WIDTH-1:0];
        assign bus.tcdm_wen_o[h]   = half_q[h].wen;
        assign bus.tcdm_wdata_o[h] = half_q[h].wdata;
        assign bus.tcdm_be_o[h]    = half_q[h].be;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (accept) state_d = StIssue;
            StIssue: if (&granted) state_d = StWait;
            StWait:  if (&done) state_d = StResp;
            StResp:  state_d = accept ? StIssue : StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Byte-offset bits and the unused upper part of the wide half address.
    logic unused_bits;
    assign unused_bits = ^{bus.add_i[2:0], half_q[LO].addr, half_q[HI].addr};

endmodule

// File: tb/tb_l2_tcdm_64to32_split.sv
// Scoreboard bench for l2_tcdm_64to32_split: a word-memory reference model predicts merged
// responses and per-half TCDM requests; a TCDM slave model and a monitor check them.
module tb_l2_tcdm_64to32_split;

    localparam int unsigned AW = 32;

    typedef struct packed {
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  be;
    } hreq_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int unsigned cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    l2_tcdm_64to32_split_if #(.ADDR_WIDTH(AW)) bus ();

    l2_tcdm_64to32_split #(.ADDR_WIDTH(AW)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    int checks = 0;
    int failures = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Reference model state
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] slv_mem [logic [31:0]];
    logic [63:0] exp_q [$];
    hreq_t       hexp_q0 [$];
    hreq_t       hexp_q1 [$];
    int unsigned acc_cyc_q [$];

    function automatic logic [31:0] init_word(logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    task automatic model_accept(logic [31:0] a, logic w, logic [63:0] d, logic [7:0] b);
        logic [31:0] base, wa, word;
        logic [3:0]  hb;
        logic [63:0] exp;
        bit          sk;
        hreq_t       hx;
        base = {a[31:3], 3'b000};
        exp  = '0;
        for (int h = 0; h < 2; h++) begin
            wa   = base + 32'(4 * h);
            word = ref_mem.exists(wa) ? ref_mem[wa] : init_word(wa);
            hb   = b[4*h +: 4];
            sk   = 1'b0;
`ifdef L2_SPLIT_BE_SKIP_EN
            sk = !w && (hb == 4'h0);
`endif
            if (!w) begin
                for (int k = 0; k < 4; k++)
                    if (hb[k]) word[8*k +: 8] = d[32*h + 8*k +: 8];
                ref_mem[wa] = word;
            end
            exp[32*h +: 32] = sk ? 32'h0 : word;
            hx = '{addr: wa, wen: w, wdata: d[32*h +: 32], be: hb};
            if (!sk) begin
                if (h == 0) hexp_q0.push_back(hx);
                else        hexp_q1.push_back(hx);
            end
        end
        exp_q.push_back(exp);
    endtask

    // TCDM slave model: per-half grant stall and response latency (-1 = random)
    int          stall_force [2];
    int          lat_force [2];
    bit          stall_armed [2];
    int          stall [2];
    bit          pend [2];
    int          cnt [2];
    logic [31:0] pdata [2];

    task automatic set_timing(int s0, int s1, int l0, int l1);
        stall_force[0] = s0; stall_force[1] = s1;
        lat_force[0]   = l0; lat_force[1]   = l1;
        stall_armed[0] = 0;  stall_armed[1] = 0;
    endtask

    task automatic slave_grant(int h);
        hreq_t       got, ex;
        int          avail;
        logic [31:0] word;
        got = '{addr: bus.tcdm_add_o[h], wen: bus.tcdm_wen_o[h],
                wdata: bus.tcdm_wdata_o[h], be: bus.tcdm_be_o[h]};
        avail = (h == 0) ? hexp_q0.size() : hexp_q1.size();
        check($sformatf("tcdm_req_expected_h%0d", h), 64'(avail > 0), 64'd1);
        if (avail > 0) begin
            ex = (h == 0) ? hexp_q0.pop_front() : hexp_q1.pop_front();
            check($sformatf("tcdm_addr_h%0d", h), 64'(got.addr), 64'(ex.addr));
            check($sformatf("tcdm_wen_wdata_be_h%0d", h), 64'({got.wen, got.wdata, got.be}),
                  64'({ex.wen, ex.wdata, ex.be}));
        end
        word = slv_mem.exists(got.addr) ? slv_mem[got.addr] : init_word(got.addr);
        if (!got.wen) begin
            for (int k = 0; k < 4; k++)
                if (got.be[k]) word[8*k +: 8] = got.wdata[8*k +: 8];
            slv_mem[got.addr] = word;
        end
        pend[h]  = 1'b1;
        pdata[h] = word;
        cnt[h]   = (lat_force[h] >= 0) ? lat_force[h] : int'($urandom_range(0, 2));
    endtask

    always @(negedge clk) begin
        for (int h = 0; h < 2; h++) begin
            bus.tcdm_r_valid_i[h] = 1'b0;
            bus.tcdm_r_rdata_i[h] = $urandom;
            if (pend[h]) begin
                if (cnt[h] == 0) begin
                    bus.tcdm_r_valid_i[h] = 1'b1;
                    bus.tcdm_r_rdata_i[h] = pdata[h];
                    pend[h] = 1'b0;
                end else begin
                    cnt[h]--;
                end
            end
            // Random grant noise while not requested must be ignored by the DUT.
            bus.tcdm_gnt_i[h] = 1'($urandom_range(0, 1));
            if (bus.tcdm_req_o[h] && rst_n) begin
                bus.tcdm_gnt_i[h] = 1'b0;
                if (!stall_armed[h]) begin
                    stall[h] = (stall_force[h] >= 0) ? stall_force[h]
                                                     : int'($urandom_range(0, 2));
                    stall_armed[h] = 1'b1;
                end
                if (stall[h] == 0) begin
                    bus.tcdm_gnt_i[h] = 1'b1;
                    stall_armed[h] = 1'b0;
                    slave_grant(h);
                end else begin
                    stall[h]--;
                end
            end
        end
    end

    // Monitor
    int          rv_count = 0;
    int unsigned rv_last = 0;
    logic [63:0] last_rdata = '0;

    always @(negedge clk) begin
        if (rst_n && bus.r_valid_o) begin
            rv_count++;
            rv_last = cyc;
            last_rdata = bus.r_rdata_o;
            check("r_valid_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) check("r_rdata", bus.r_rdata_o, exp_q.pop_front());
        end
    end

    task automatic send(logic [31:0] a, logic w, logic [63:0] d, logic [7:0] b);
        int n = 0;
        bus.req_i = 1'b1; bus.add_i = a; bus.wen_i = w; bus.wdata_i = d; bus.be_i = b;
        #1;
        while (!bus.gnt_o && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("upstream_gnt", 64'(bus.gnt_o), 64'd1);
        if (bus.gnt_o) begin
            model_accept(a, w, d, b);
            acc_cyc_q.push_back(cyc);
        end
        @(negedge clk);
        bus.req_i = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        #1;
        check("drain_pending", 64'(exp_q.size()), 64'd0);
    endtask

    function automatic logic any_output();
        return |{bus.gnt_o, bus.r_valid_o, bus.r_rdata_o, bus.tcdm_req_o, bus.tcdm_add_o,
                 bus.tcdm_wen_o, bus.tcdm_wdata_o, bus.tcdm_be_o};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int          n0;
        int          rv0;
        logic [1:0]  exp_req;
        bus.req_i = 1'b0; bus.add_i = '0; bus.wen_i = 1'b1; bus.wdata_i = '0; bus.be_i = '0;
        bus.tcdm_gnt_i = '0; bus.tcdm_r_valid_i = '0; bus.tcdm_r_rdata_i = '0;
        set_timing(0, 0, 0, 0);
        repeat (3) @(negedge clk);
        check("reset_outputs_zero", 64'(any_output()), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Best-case read
        ref_mem[32'h1C00_0010] = 32'hAAAA_0000; slv_mem[32'h1C00_0010] = 32'hAAAA_0000;
        ref_mem[32'h1C00_0014] = 32'hBBBB_1111; slv_mem[32'h1C00_0014] = 32'hBBBB_1111;
        send(32'h1C00_0010, 1'b1, 64'h0, 8'hFF);
        drain();
        check("read_latency", 64'(rv_last - acc_cyc_q[$]), 64'd3);
        check("read_rdata", last_rdata, 64'hBBBB_1111_AAAA_0000);

        // Write with the hi grant stalled 4 cycles
        set_timing(0, 4, 0, 0);
        rv0 = rv_count;
        send(32'h1C00_0100, 1'b0, 64'h1122_3344_5566_7788, 8'hFF);
        drain();
        check("stalled_write_latency", 64'(rv_last - acc_cyc_q[$]), 64'd7);
        check("stalled_write_rv_count", 64'(rv_count - rv0), 64'd1);

        // Misaligned address
        set_timing(0, 0, 0, 0);
        send(32'h1C00_000D, 1'b1, 64'h0, 8'hFF);
        check("misaligned_lo_addr", 64'(bus.tcdm_add_o[0]), 64'h1C00_0008);
        check("misaligned_hi_addr", 64'(bus.tcdm_add_o[1]), 64'h1C00_000C);
        drain();

        // Back-to-back: req_i held across three transactions
        n0  = acc_cyc_q.size();
        rv0 = rv_count;
        send(32'h1C00_0020, 1'b1, 64'h0, 8'hFF);
        send(32'h1C00_0028, 1'b0, {$urandom, $urandom}, 8'hA5);
        send(32'h1C00_0028, 1'b1, 64'h0, 8'hFF);
        check("b2b_accept_gap1", 64'(acc_cyc_q[n0+1] - acc_cyc_q[n0]), 64'd3);
        check("b2b_accept_gap2", 64'(acc_cyc_q[n0+2] - acc_cyc_q[n0+1]), 64'd3);
        drain();
        check("b2b_rv_count", 64'(rv_count - rv0), 64'd3);

        // Reset in WAIT with the hi response still outstanding
        set_timing(0, 0, 0, 6);
        rv0 = rv_count;
        send(32'h1C00_0030, 1'b1, 64'h0, 8'hFF);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete(); hexp_q0.delete(); hexp_q1.delete();
        #1;
        check("midop_reset_outputs_zero", 64'(any_output()), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("reset_no_r_valid", 64'(rv_count - rv0), 64'd0);
        set_timing(-1, -1, -1, -1);
        send(32'h1C00_0030, 1'b1, 64'h0, 8'hFF);
        drain();
        check("post_reset_rv_count", 64'(rv_count - rv0), 64'd1);

        // Write touching only the lo half
        set_timing(0, 0, 0, 0);
`ifdef L2_SPLIT_BE_SKIP_EN
        exp_req = 2'b01;
`else
        exp_req = 2'b11;
`endif
        send(32'h1C00_0200, 1'b0, {$urandom, $urandom}, 8'h0F);
        check("lo_only_write_req", 64'(bus.tcdm_req_o), 64'(exp_req));
        drain();

        // Randomized traffic over a small window so reads hit earlier writes
        set_timing(-1, -1, -1, -1);
        for (int i = 0; i < 40; i++) begin
            logic [7:0] b;
            case ($urandom_range(0, 4))
                0:       b = 8'h0F;
                1:       b = 8'hF0;
                default: b = 8'($urandom);
            endcase
            send(32'h1C00_0000 + 32'($urandom_range(0, 63)), 1'($urandom_range(0, 1)),
                 {$urandom, $urandom}, b);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        drain();
        repeat (10) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
